// File: rtl/address_aligner.sv
// Registered address-alignment unit: aligns a byte address to the access size
// (down or up) and reports offset, little-endian byte lanes and address errors.
module address_aligner #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] dir,
  input  logic [1:0]        size,
  input  logic              round_up,
  output logic              valid_out,
  output logic [ADDR_W-1:0] dirOut,
  output logic [2:0]        offset,
  output logic [3:0]        byte_en,
  output logic              misaligned,
  output logic              wrap
);

  logic [2:0]        mask;
  logic [ADDR_W-1:0] mask_w;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W-1:0] aligned_nxt;
  logic              wrap_nxt;
  logic [2:0]        offset_nxt;
  logic              mis_nxt;
  logic [3:0]        lanes_nxt;

  always_comb begin
    mask = 3'd0;
    case (size)
      2'b00: mask = 3'd0;
      2'b01: mask = 3'd1;
      2'b10: mask = 3'd3;
      2'b11: mask = 3'd7;
      default: mask = 3'd0;
    endcase
    mask_w = {{(ADDR_W-3){1'b0}}, mask};

    // Extra carry bit catches round-up past the top of the address space
    sum         = {1'b0, dir} + {1'b0, mask_w};
    aligned_nxt = round_up ? (sum[ADDR_W-1:0] & ~mask_w) : (dir & ~mask_w);
    wrap_nxt    = round_up & sum[ADDR_W];

    offset_nxt = dir[2:0] & mask;
    mis_nxt    = |offset_nxt;

    lanes_nxt = 4'b0000;
    case (size)
      2'b00:   lanes_nxt = 4'b0001 << dir[1:0];
      2'b01:   lanes_nxt = dir[1] ? 4'b1100 : 4'b0011;
      default: lanes_nxt = 4'b1111;
    endcase
    if (mis_nxt)
      lanes_nxt = 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out  <= 1'b0;
      dirOut     <= '0;
      offset     <= 3'd0;
      byte_en    <= 4'd0;
      misaligned <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        dirOut     <= aligned_nxt;
        offset     <= offset_nxt;
        byte_en    <= lanes_nxt;
        misaligned <= mis_nxt;
        wrap       <= wrap_nxt;
      end
    end
  end

endmodule

// File: tb/tb_address_aligner.sv
// Directed-vector bench for address_aligner: table of hand-computed results
// applied back-to-back, plus reset and hold sequences.
module tb_address_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] dir;
  logic [1:0]  size;
  logic        round_up;
  logic        valid_out;
  logic [31:0] dirOut;
  logic [2:0]  offset;
  logic [3:0]  byte_en;
  logic        misaligned;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  address_aligner #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .dir(dir), .size(size),
    .round_up(round_up), .valid_out(valid_out), .dirOut(dirOut),
    .offset(offset), .byte_en(byte_en), .misaligned(misaligned), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dir;
    logic [1:0]  size;
    logic        up;
    logic [31:0] e_dir;
    logic [2:0]  e_off;
    logic [3:0]  e_be;
    logic        e_mis;
    logic        e_wrap;
  } vec_t;

  vec_t vecs [0:31];
  int   nv = 0;

  task automatic add(input logic [31:0] d, input logic [1:0] s, input logic up,
                     input logic [31:0] ed, input logic [2:0] eo, input logic [3:0] eb,
                     input logic em, input logic ew);
    vec_t v;
    v.dir = d; v.size = s; v.up = up; v.e_dir = ed; v.e_off = eo;
    v.e_be = eb; v.e_mis = em; v.e_wrap = ew;
    vecs[nv] = v;
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                           input logic [2:0] eo, input logic [3:0] eb,
                           input logic em, input logic ew);
    check({tag, ".valid_out"},  {31'd0, valid_out},  {31'd0, ev});
    check({tag, ".dirOut"},     dirOut,              ed);
    check({tag, ".offset"},     {29'd0, offset},     {29'd0, eo});
    check({tag, ".byte_en"},    {28'd0, byte_en},    {28'd0, eb});
    check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, em});
    check({tag, ".wrap"},       {31'd0, wrap},       {31'd0, ew});
  endtask

  initial begin
    // word, down
    add(3414,  2'b10, 0, 3412,  3'd2, 4'b0000, 1, 0);
    add(1,     2'b10, 0, 0,     3'd1, 4'b0000, 1, 0);
    add(12523, 2'b10, 0, 12520, 3'd3, 4'b0000, 1, 0);
    add(9890,  2'b10, 0, 9888,  3'd2, 4'b0000, 1, 0);
    add(12,    2'b10, 0, 12,    3'd0, 4'b1111, 0, 0);
    add(888,   2'b10, 0, 888,   3'd0, 4'b1111, 0, 0);
    add(6666,  2'b10, 0, 6664,  3'd2, 4'b0000, 1, 0);
    add(777,   2'b10, 0, 776,   3'd1, 4'b0000, 1, 0);
    // word, up
    add(3414,  2'b10, 1, 3416,  3'd2, 4'b0000, 1, 0);
    add(12,    2'b10, 1, 12,    3'd0, 4'b1111, 0, 0);
    add(777,   2'b10, 1, 780,   3'd1, 4'b0000, 1, 0);
    add(32'hFFFF_FFFD, 2'b10, 1, 32'h0, 3'd1, 4'b0000, 1, 1);
    // halfword, down
    add(9890,  2'b01, 0, 9890,  3'd0, 4'b1100, 0, 0);
    add(777,   2'b01, 0, 776,   3'd1, 4'b0000, 1, 0);
    add(9888,  2'b01, 0, 9888,  3'd0, 4'b0011, 0, 0);
    // byte: never misaligned, rounding has no effect
    add(12523, 2'b00, 0, 12523, 3'd0, 4'b1000, 0, 0);
    add(12520, 2'b00, 1, 12520, 3'd0, 4'b0001, 0, 0);
    add(32'hFFFF_FFFE, 2'b00, 1, 32'hFFFF_FFFE, 3'd0, 4'b0100, 0, 0);
    // doubleword
    add(6666,  2'b11, 0, 6664,  3'd2, 4'b0000, 1, 0);
    add(6666,  2'b11, 1, 6672,  3'd2, 4'b0000, 1, 0);
    add(6672,  2'b11, 0, 6672,  3'd0, 4'b1111, 0, 0);
    add(32'hFFFF_FFF9, 2'b11, 1, 32'h0, 3'd1, 4'b0000, 1, 1);
    add(32'hFFFF_FFF9, 2'b11, 0, 32'hFFFF_FFF8, 3'd1, 4'b0000, 1, 0);

    // Reset with valid_in toggling underneath
    rst = 1'b1; valid_in = 1'b0; dir = 32'h1234_5677; size = 2'b10; round_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_in = ~valid_in;
    end
    check_all("reset", 0, 0, 3'd0, 4'd0, 0, 0);

    @(negedge clk);
    rst = 1'b0; valid_in = 1'b1; dir = 0; size = 2'b10; round_up = 1'b0;
    @(posedge clk); #1;
    check_all("first", 1, 0, 3'd0, 4'b1111, 0, 0);

    // Back-to-back table; before each edge the previous result must still be shown
    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      dir = vecs[i].dir; size = vecs[i].size; round_up = vecs[i].up; valid_in = 1'b1;
      #1;
      if (i > 0) check($sformatf("latency[%0d].dirOut", i), dirOut, vecs[i-1].e_dir);
      @(posedge clk); #1;
      check_all($sformatf("vec[%0d]", i), 1, vecs[i].e_dir, vecs[i].e_off,
                vecs[i].e_be, vecs[i].e_mis, vecs[i].e_wrap);
    end

    // valid_in low: data holds, valid_out drops
    @(negedge clk);
    valid_in = 1'b1; dir = 3414; size = 2'b10; round_up = 1'b0;
    @(negedge clk);
    valid_in = 1'b0; dir = 888; size = 2'b01; round_up = 1'b1;
    @(posedge clk); #1;
    check_all("hold1", 0, 3412, 3'd2, 4'b0000, 1, 0);
    @(posedge clk); #1;
    check_all("hold2", 0, 3412, 3'd2, 4'b0000, 1, 0);

    // Asynchronous reset between edges clears a result in flight
    @(negedge clk);
    valid_in = 1'b1; dir = 32'hFFFF_FFFD; size = 2'b10; round_up = 1'b1;
    @(posedge clk); #1;
    check_all("pre_rst", 1, 0, 3'd1, 4'b0000, 1, 1);
    @(negedge clk);
    valid_in = 1'b1; dir = 12523; size = 2'b00; round_up = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 3'd0, 4'd0, 0, 0);
    @(posedge clk); #1;
    check_all("rst_held", 0, 0, 3'd0, 4'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst", 0, 0, 3'd0, 4'd0, 0, 0);
    @(negedge clk);
    valid_in = 1'b1; dir = 12523; size = 2'b00; round_up = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst_vec", 1, 12523, 3'd0, 4'b1000, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/address_aligner.md
Name: address_aligner

Overview:
- Registered address-alignment unit for the MIPS memory path, between address generation (ALU/PC) and data memory.
- Aligns a 32-bit byte address to the access size: down by default, or up on request.
- Also produces the byte offset, little-endian byte-lane enables and a misalignment/address-error flag.
- One-cycle registered latency, valid-qualified.

Parameters:
- ADDR_W, 32, address width in bits (fixed at 32 for this design).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  request strobe; the address/size/mode are sampled when high.
- dir  in  32  unaligned input byte address.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 doubleword (8 B).
- round_up  in  1  0 = align down (truncate), 1 = align up to the next boundary.
- valid_out  out  1  result valid, one cycle after valid_in.
- dirOut  out  32  aligned address.
- offset  out  3  dir modulo access size (dir[2:0] masked to the size).
- byte_en  out  4  byte-lane enables within the 32-bit word, little-endian.
- misaligned  out  1  offset != 0.
- wrap  out  1  round-up overflowed past 0xFFFFFFFF.

Behaviour:
- Reset (asynchronous, rst=1): valid_out=0, dirOut=0, offset=0, byte_en=0, misaligned=0, wrap=0. These hold until the first valid_in after rst deasserts.
- All outputs are registered. The result for inputs sampled at edge N appears after edge N, i.e. latency is 1 cycle.
- valid_out(N+1) = valid_in(N).
- When valid_in=0, the data outputs hold their previous values and valid_out drops to 0.
- Alignment mask: m = 0, 1, 3, 7 for size 00, 01, 10, 11.
- Align down: dirOut = dir & ~m.
- Align up: sum = dir + m over 33 bits; dirOut = sum[31:0] & ~m; wrap = sum[32].
- wrap is always 0 in align-down mode. Example: 0xFFFFFFFD, word, up gives dirOut=0 and wrap=1.
- offset = dir & m, zero-extended to 3 bits.
- misaligned = (offset != 0). This is independent of round_up.
- byte_en, computed from dir[1:0] when not misaligned:
  - byte: one-hot (1 << dir[1:0]).
  - half: 0011 if dir[1]=0, else 1100.
  - word and doubleword: 1111.
- byte_en when misaligned: 0000, signalling an address error. dirOut is still produced normally.
- Size 00 is never misaligned; dirOut = dir and byte_en is one-hot.
- rst asserted mid-operation clears the outputs immediately, including a result in flight. No state survives reset.
- Back-to-back valid_in is accepted every cycle. There is no backpressure.
- The design is purely combinational between the input and output registers. There is no other state.

Test Plan:
- Reset: assert rst with valid_in=1 toggling -> all outputs 0. Release rst, then dir=0, word, down -> next cycle valid_out=1, dirOut=0, offset=0, byte_en=1111, misaligned=0.
- Word, align down, valid_in=1 every cycle for dir = 3414, 1, 12523, 9890, 12, 888, 6666, 777:
  - dirOut = 3412, 0, 12520, 9888, 12, 888, 6664, 776.
  - offset = 2, 1, 3, 2, 0, 0, 2, 1.
  - misaligned = 1 except for 12 and 888.
  - Each result appears exactly one cycle later.
- Word, align up, dir = 3414, 12, 777 -> dirOut = 3416, 12, 780; wrap=0. Then dir=0xFFFFFFFD -> dirOut=0, wrap=1.
- Halfword, down:
  - dir=9890 -> dirOut=9890, offset=0, byte_en=1100.
  - dir=777 -> dirOut=776, misaligned=1, byte_en=0000.
- Byte and doubleword:
  - byte, dir=12523 -> dirOut=12523, byte_en=1000.
  - doubleword, down, dir=6666 -> dirOut=6664, offset=2, misaligned=1.
- Mid-stream reset: assert rst asynchronously (between clock edges) one cycle after valid_in=1 -> outputs 0 immediately, no stale result after release. valid_in=0 cycles -> valid_out=0, dirOut holds its previous value.
